wb_rr_arbiter: RTL and testbench
================================

Name: wb_rr_arbiter

Overview:
- Shares one Wishbone B4 slave port between NUM_MASTERS masters using round-robin arbitration.
- Supports LOCK_O bus retention, routes termination and tag signals, and runs a watchdog that errors out stalled cycles.
- Sits between the master agents' interfaces and the single slave interface, replacing a direct master-to-slave pass-through.

Parameters:
- NUM_MASTERS, 4, number of requesting masters (2..8).
- AW, 32, address width.
- DW, 32, data width; SEL width = DW/8.
- TGW, 8, width of each tag field (TGA/TGC/TGD).
- TIMEOUT, 256, cycles of STB without termination before a forced ERR; 0 disables the watchdog.

Ports:
- CLK_I  in  1  clock.
- RST_I  in  1  reset.
- m_CYC_I / m_STB_I / m_WE_I / m_LOCK_I  in  NUM_MASTERS each  per-master cycle/strobe/write/lock.
- m_ADR_I  in  NUM_MASTERS*AW  per-master address, master i at [i*AW +: AW].
- m_DAT_I  in  NUM_MASTERS*DW  per-master write data.
- m_SEL_I  in  NUM_MASTERS*DW/8  per-master byte selects.
- m_TGA_I / m_TGC_I / m_TGD_I  in  NUM_MASTERS*TGW each  per-master tags.
- m_DAT_O / m_TGD_O  out  DW / TGW  read data and tag, broadcast to all masters.
- m_ACK_O / m_ERR_O / m_RTY_O  out  NUM_MASTERS each  terminations, granted master only.
- s_CYC_O / s_STB_O / s_WE_O / s_LOCK_O  out  1 each  to slave.
- s_ADR_O / s_DAT_O / s_SEL_O  out  AW / DW / DW/8  to slave.
- s_TGA_O / s_TGC_O / s_TGD_O  out  TGW each  to slave.
- s_DAT_I / s_TGD_I  in  DW / TGW  from slave.
- s_ACK_I / s_ERR_I / s_RTY_I  in  1 each  from slave.
- gnt_o  out  NUM_MASTERS  one-hot current owner; all zero when idle.
- timeout_o  out  1  one-cycle pulse on watchdog expiry.

Behaviour:
- Single clock CLK_I. RST_I is synchronous and active-high.
- Reset state: state=IDLE, gnt_o=0, round-robin pointer=0, watchdog=0. All s_* outputs 0, all m_ACK_O/m_ERR_O/m_RTY_O 0, timeout_o 0.
- Reset mid-cycle: s_CYC_O is low from the first cycle after the reset edge. The in-flight transfer is abandoned and no termination is forwarded.
- States: IDLE and OWN.
- IDLE to OWN: on any m_CYC_I high, register a one-hot grant for the first requester at or after the pointer, searching upward and wrapping modulo NUM_MASTERS.
  - Grant latency: one cycle from m_CYC_I to s_CYC_O.
- In OWN, s_* outputs are combinational copies of the granted master's signals: s_CYC_O=m_CYC_I[g], s_STB_O=m_STB_I[g]&m_CYC_I[g], plus ADR/DAT/SEL/WE/LOCK/tags.
  - In IDLE all s_* outputs are 0.
- Terminations: m_ACK_O[g]=s_ACK_I, m_RTY_O[g]=s_RTY_I, m_ERR_O[g]=s_ERR_I|timeout_o. Non-granted masters see 0.
  - m_DAT_O=s_DAT_I and m_TGD_O=s_TGD_I, unconditionally.
- OWN to IDLE: when m_CYC_I[g]=0 and m_LOCK_I[g]=0. On this transition the pointer becomes (g+1) mod NUM_MASTERS.
  - Minimum one IDLE turnaround cycle between different owners.
- Lock: while m_LOCK_I[g]=1 the grant is retained even with m_CYC_I[g]=0. s_CYC_O follows m_CYC_I[g] and s_LOCK_O=1. Other requesters wait.
- Watchdog:
  - Counts cycles in OWN with s_STB_O=1 and no ACK/ERR/RTY. Clears on any termination, on STB low, and in IDLE.
  - On reaching TIMEOUT it pulses timeout_o and ERR to the granted master for one cycle, then clears.
  - If a slave termination arrives in the same cycle the count reaches TIMEOUT, the slave termination wins: no timeout pulse, counter cleared.
  - The arbiter does not drop s_STB_O; the master must react to the ERR.
- Simultaneous requests: exactly one grant. A request asserted in the same cycle as release is evaluated in the following IDLE cycle.
- Requests during OWN from non-owners are ignored until IDLE; m_CYC_I must stay high to be considered.

Test Plan:
- Reset, then master 2 asserts CYC/STB write ADR=0x100 -> gnt_o=0100 one cycle later; s_ADR_O=0x100, s_WE_O=1; slave ACK reaches only m_ACK_O[2].
- Masters 0,1,3 request continuously from reset -> grant order 0,1,3,0,…, one IDLE cycle between owners, never two bits in gnt_o.
- Master 1 holds LOCK_I=1 across two CYC bursts with a 3-cycle CYC gap while master 0 requests -> gnt_o stays 0010 until LOCK drops; master 0 is granted one cycle after the IDLE turnaround.
- TIMEOUT=8, slave never terminates -> exactly 8 cycles after STB, timeout_o and m_ERR_O[g] pulse for 1 cycle; a slave ACK on cycle 8 instead -> ACK only, no timeout.
- Read with s_DAT_I=0xDEADBEEF, s_TGD_I=0x5A -> m_DAT_O=0xDEADBEEF, m_TGD_O=0x5A, m_ACK_O only for the owner.
- Assert RST_I for 1 cycle mid-burst of master 3 -> next cycle s_CYC_O=0, gnt_o=0, and the pointer restarts at master 0.

Source files
------------

// File: rtl/wb_rr_arbiter_if.sv
// Wishbone B4 bundle of N parallel master-side channels with one broadcast read-data/tag return.
// The "master" modport is the view of whoever initiates cycles; "slave" is the responder.
interface wb_rr_arbiter_if #(
    parameter int N   = 1,
    parameter int AW  = 32,
    parameter int DW  = 32,
    parameter int TGW = 8
);
    logic [N-1:0]        cyc;
    logic [N-1:0]        stb;
    logic [N-1:0]        we;
    logic [N-1:0]        lock;
    logic [N*AW-1:0]     adr;
    logic [N*DW-1:0]     dat_w;
    logic [N*DW/8-1:0]   sel;
    logic [N*TGW-1:0]    tga;
    logic [N*TGW-1:0]    tgc;
    logic [N*TGW-1:0]    tgd_w;
    logic [DW-1:0]       dat_r;
    logic [TGW-1:0]      tgd_r;
    logic [N-1:0]        ack;
    logic [N-1:0]        err;
    logic [N-1:0]        rty;

    modport master (
        output cyc, stb, we, lock, adr, dat_w, sel, tga, tgc, tgd_w,
        input  dat_r, tgd_r, ack, err, rty
    );

    modport slave (
        input  cyc, stb, we, lock, adr, dat_w, sel, tga, tgc, tgd_w,
        output dat_r, tgd_r, ack, err, rty
    );
endinterface

// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone B4 arbiter: NUM_MASTERS masters share one slave, with LOCK retention
// and a watchdog that forces ERR on a strobe left unterminated for TIMEOUT cycles.
module wb_rr_arbiter #(
    parameter int NUM_MASTERS = 4,
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int TGW         = 8,
    parameter int TIMEOUT     = 256
) (
    input  logic                   CLK_I,
    input  logic                   RST_I,
    wb_rr_arbiter_if.slave         m,
    wb_rr_arbiter_if.master        s,
    output logic [NUM_MASTERS-1:0] gnt_o,
    output logic                   timeout_o
);
    localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int SW = DW / 8;

    typedef enum logic {IDLE, OWN} state_t;

    state_t                 state, state_n;
    logic [NUM_MASTERS-1:0] gnt, gnt_n;
    logic [IW-1:0]          owner, owner_n;
    logic [IW-1:0]          ptr, ptr_n;
    logic [IW-1:0]          pick;
    logic [CW-1:0]          wdog, wdog_n;
    logic                   found;
    logic                   term, stall, expired;

    logic                   own_cyc, own_stb, own_we, own_lock;
    logic [AW-1:0]          own_adr;
    logic [DW-1:0]          own_dat;
    logic [SW-1:0]          own_sel;
    logic [TGW-1:0]         own_tga, own_tgc, own_tgd;

    // First requester at or after the pointer, wrapping around.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (!found && m.cyc[IW'((int'(ptr) + i) % NUM_MASTERS)]) begin
                found = 1'b1;
                pick  = IW'((int'(ptr) + i) % NUM_MASTERS);
            end
        end
    end

    always_comb begin
        own_cyc  = 1'b0;
        own_stb  = 1'b0;
        own_we   = 1'b0;
        own_lock = 1'b0;
        own_adr  = '0;
        own_dat  = '0;
        own_sel  = '0;
        own_tga  = '0;
        own_tgc  = '0;
        own_tgd  = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (owner == IW'(i)) begin
                own_cyc  = m.cyc[i];
                own_stb  = m.stb[i] & m.cyc[i];
                own_we   = m.we[i];
                own_lock = m.lock[i];
                own_adr  = m.adr[i*AW +: AW];
                own_dat  = m.dat_w[i*DW +: DW];
                own_sel  = m.sel[i*SW +: SW];
                own_tga  = m.tga[i*TGW +: TGW];
                own_tgc  = m.tgc[i*TGW +: TGW];
                own_tgd  = m.tgd_w[i*TGW +: TGW];
            end
        end
    end

    always_comb begin
        s.cyc   = '0;
        s.stb   = '0;
        s.we    = '0;
        s.lock  = '0;
        s.adr   = '0;
        s.dat_w = '0;
        s.sel   = '0;
        s.tga   = '0;
        s.tgc   = '0;
        s.tgd_w = '0;
        if (state == OWN) begin
            s.cyc   = own_cyc;
            s.stb   = own_stb;
            s.we    = own_we;
            s.lock  = own_lock;
            s.adr   = own_adr;
            s.dat_w = own_dat;
            s.sel   = own_sel;
            s.tga   = own_tga;
            s.tgc   = own_tgc;
            s.tgd_w = own_tgd;
        end
    end

    // A real slave termination in the expiry cycle suppresses the forced ERR.
    always_comb begin
        term    = s.ack[0] | s.err[0] | s.rty[0];
        stall   = (state == OWN) && own_stb && !term;
        expired = (TIMEOUT != 0) && stall && (wdog == CW'(TIMEOUT));
        wdog_n  = '0;
        if ((TIMEOUT != 0) && stall && !expired) begin
            wdog_n = wdog + CW'(1);
        end
    end

    always_comb begin
        m.ack   = gnt & {NUM_MASTERS{s.ack[0]}};
        m.rty   = gnt & {NUM_MASTERS{s.rty[0]}};
        m.err   = gnt & {NUM_MASTERS{s.err[0] | expired}};
        m.dat_r = s.dat_r;
        m.tgd_r = s.tgd_r;
    end

    // Releasing always passes through IDLE, giving the one-cycle turnaround between owners.
    always_comb begin
        state_n = state;
        gnt_n   = gnt;
        owner_n = owner;
        ptr_n   = ptr;
        case (state)
            IDLE: begin
                if (found) begin
                    state_n     = OWN;
                    owner_n     = pick;
                    gnt_n       = '0;
                    gnt_n[pick] = 1'b1;
                end
            end
            OWN: begin
                if (!own_cyc && !own_lock) begin
                    state_n = IDLE;
                    gnt_n   = '0;
                    ptr_n   = (owner == IW'(NUM_MASTERS - 1)) ? '0 : owner + IW'(1);
                end
            end
            default: begin
                state_n = IDLE;
                gnt_n   = '0;
            end
        endcase
    end

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state <= IDLE;
            gnt   <= '0;
            owner <= '0;
            ptr   <= '0;
            wdog  <= '0;
        end else begin
            state <= state_n;
            gnt   <= gnt_n;
            owner <= owner_n;
            ptr   <= ptr_n;
            wdog  <= wdog_n;
        end
    end

    assign gnt_o     = gnt;
    assign timeout_o = expired;
endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed bench for wb_rr_arbiter: 4 masters, TIMEOUT=8; inputs driven 1ns after the
// rising edge, outputs sampled on the falling edge.
module tb_wb_rr_arbiter;
    localparam int N   = 4;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int TGW = 8;
    localparam int TO  = 8;

    logic         CLK_I = 1'b0;
    logic         RST_I = 1'b1;
    logic [N-1:0] gnt_o;
    logic         timeout_o;
    int           errors = 0;
    int           checks = 0;

    wb_rr_arbiter_if #(.N(N), .AW(AW), .DW(DW), .TGW(TGW)) mbus ();
    wb_rr_arbiter_if #(.N(1), .AW(AW), .DW(DW), .TGW(TGW)) sbus ();

    wb_rr_arbiter #(.NUM_MASTERS(N), .AW(AW), .DW(DW), .TGW(TGW), .TIMEOUT(TO)) dut (
        .CLK_I     (CLK_I),
        .RST_I     (RST_I),
        .m         (mbus),
        .s         (sbus),
        .gnt_o     (gnt_o),
        .timeout_o (timeout_o)
    );

    always #5 CLK_I = ~CLK_I;

    task automatic tick();
        @(posedge CLK_I);
        #1;
    endtask

    task automatic clear_inputs();
        mbus.cyc   = '0;
        mbus.stb   = '0;
        mbus.we    = '0;
        mbus.lock  = '0;
        mbus.adr   = '0;
        mbus.dat_w = '0;
        mbus.sel   = '0;
        mbus.tga   = '0;
        mbus.tgc   = '0;
        mbus.tgd_w = '0;
        sbus.dat_r = '0;
        sbus.tgd_r = '0;
        sbus.ack   = '0;
        sbus.err   = '0;
        sbus.rty   = '0;
    endtask

    task automatic set_master(input int i, input logic we, input logic [AW-1:0] adr);
        mbus.cyc[i]               = 1'b1;
        mbus.stb[i]               = 1'b1;
        mbus.we[i]                = we;
        mbus.adr[i*AW +: AW]      = adr;
        mbus.dat_w[i*DW +: DW]    = 32'hA000_0000 | adr;
        mbus.sel[i*(DW/8) +: DW/8] = '1;
        mbus.tga[i*TGW +: TGW]    = TGW'(8'h10 + i);
    endtask

    task automatic drop_master(input int i);
        mbus.cyc[i] = 1'b0;
        mbus.stb[i] = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        RST_I = 1'b1;
        tick();
        tick();
        @(negedge CLK_I);
        checks++; if (gnt_o !== 4'b0000) begin errors++; $display("[TB] FAIL reset_gnt: got %b expected 0000", gnt_o); end
        checks++; if (sbus.cyc !== 1'b0 || sbus.stb !== 1'b0) begin errors++; $display("[TB] FAIL reset_cyc_stb: got %b/%b expected 0/0", sbus.cyc, sbus.stb); end
        checks++; if (timeout_o !== 1'b0 || mbus.ack !== 4'b0000) begin errors++; $display("[TB] FAIL reset_term: got timeout=%b ack=%b expected 0/0000", timeout_o, mbus.ack); end
        tick();
        RST_I = 1'b0;
    endtask

    task automatic test_single_write();
        set_master(2, 1'b1, 32'h100);
        @(negedge CLK_I);
        checks++; if (gnt_o !== 4'b0000 || sbus.cyc !== 1'b0) begin errors++; $display("[TB] FAIL grant_latency: got gnt=%b cyc=%b expected 0000/0", gnt_o, sbus.cyc); end
        tick();
        @(negedge CLK_I);
        checks++; if (gnt_o !== 4'b0100) begin errors++; $display("[TB] FAIL write_gnt: got %b expected 0100", gnt_o); end
        checks++; if (sbus.cyc !== 1'b1 || sbus.stb !== 1'b1 || sbus.we !== 1'b1) begin errors++; $display("[TB] FAIL write_ctrl: got cyc=%b stb=%b we=%b expected 1/1/1", sbus.cyc, sbus.stb, sbus.we); end
        checks++; if (sbus.adr !== 32'h100) begin errors++; $display("[TB] FAIL write_adr: got %h expected 00000100", sbus.adr); end
        checks++; if (sbus.dat_w !== 32'hA000_0100 || sbus.tga !== 8'h12) begin errors++; $display("[TB] FAIL write_dat_tga: got %h/%h expected a0000100/12", sbus.dat_w, sbus.tga); end
        sbus.ack = 1'b1;
        #1;
        checks++; if (mbus.ack !== 4'b0100 || mbus.err !== 4'b0000) begin errors++; $display("[TB] FAIL write_ack_route: got ack=%b err=%b expected 0100/0000", mbus.ack, mbus.err); end
        tick();
        sbus.ack = 1'b0;
        drop_master(2);
        @(negedge CLK_I);
        checks++; if (sbus.cyc !== 1'b0 || mbus.ack !== 4'b0000) begin errors++; $display("[TB] FAIL write_release: got cyc=%b ack=%b expected 0/0000", sbus.cyc, mbus.ack); end
        tick();
        @(negedge CLK_I);
        checks++; if (gnt_o !== 4'b0000) begin errors++; $display("[TB] FAIL write_idle: got %b expected 0000", gnt_o); end
    endtask

    task automatic test_read_tags();
        tick();
        set_master(0, 1'b0, 32'h40);
        sbus.dat_r = 32'hDEAD_BEEF;
        sbus.tgd_r = 8'h5A;
        tick();
        sbus.ack = 1'b1;
        @(negedge CLK_I);
        checks++; if (gnt_o !== 4'b0001 || sbus.we !== 1'b0) begin errors++; $display("[TB] FAIL read_gnt: got gnt=%b we=%b expected 0001/0", gnt_o, sbus.we); end
        checks++; if (mbus.dat_r !== 32'hDEAD_BEEF || mbus.tgd_r !== 8'h5A) begin errors++; $display("[TB] FAIL read_data: got %h/%h expected deadbeef/5a", mbus.dat_r, mbus.tgd_r); end
        checks++; if (mbus.ack !== 4'b0001) begin errors++; $display("[TB] FAIL read_ack_route: got %b expected 0001", mbus.ack); end
        tick();
        sbus.ack = 1'b0;
        drop_master(0);
        tick();
        tick();
    endtask

    task automatic test_round_robin();
        logic [N-1:0] exp [15];
        exp = '{4'b0000, 4'b0001, 4'b0001, 4'b0000, 4'b0010, 4'b0010, 4'b0000, 4'b1000,
                4'b1000, 4'b0000, 4'b0001, 4'b0001, 4'b0000, 4'b0010, 4'b0010};
        clear_inputs();
        RST_I = 1'b1;
        tick();
        RST_I = 1'b0;
        mbus.cyc = 4'b1011;
        mbus.stb = 4'b1011;
        for (int c = 0; c < 15; c++) begin
            if (c > 0) begin
                tick();
                sbus.ack = 1'b0;
                mbus.cyc = 4'b1011;
                if (exp[c-1] != 4'b0000 && (c == 1 || exp[c-2] == 4'b0000)) begin
                    mbus.cyc = 4'b1011 & ~exp[c-1];
                end
                mbus.stb = mbus.cyc;
                if (exp[c] != 4'b0000 && exp[c-1] == 4'b0000) begin
                    sbus.ack = 1'b1;
                end
            end
            @(negedge CLK_I);
            checks++; if (gnt_o !== exp[c]) begin errors++; $display("[TB] FAIL rr_cycle%0d: got %b expected %b", c, gnt_o, exp[c]); end
        end
        tick();
        clear_inputs();
        tick();
        tick();
    endtask

    task automatic test_lock();
        RST_I = 1'b1;
        tick();
        RST_I = 1'b0;
        set_master(1, 1'b1, 32'h200);
        mbus.lock[1] = 1'b1;
        tick();
        set_master(0, 1'b0, 32'h300);
        sbus.ack = 1'b1;
        @(negedge CLK_I);
        checks++; if (gnt_o !== 4'b0010 || sbus.lock !== 1'b1) begin errors++; $display("[TB] FAIL lock_first: got gnt=%b lock=%b expected 0010/1", gnt_o, sbus.lock); end
        tick();
        sbus.ack = 1'b0;
        drop_master(1);
        for (int g = 0; g < 3; g++) begin
            if (g > 0) tick();
            @(negedge CLK_I);
            checks++; if (gnt_o !== 4'b0010 || sbus.cyc !== 1'b0 || sbus.lock !== 1'b1) begin errors++; $display("[TB] FAIL lock_gap%0d: got gnt=%b cyc=%b lock=%b expected 0010/0/1", g, gnt_o, sbus.cyc, sbus.lock); end
        end
        tick();
        set_master(1, 1'b1, 32'h204);
        sbus.ack = 1'b1;
        @(negedge CLK_I);
        checks++; if (gnt_o !== 4'b0010 || sbus.cyc !== 1'b1 || sbus.adr !== 32'h204) begin errors++; $display("[TB] FAIL lock_second: got gnt=%b cyc=%b adr=%h expected 0010/1/00000204", gnt_o, sbus.cyc, sbus.adr); end
        tick();
        sbus.ack = 1'b0;
        drop_master(1);
        mbus.lock[1] = 1'b0;
        @(negedge CLK_I);
        checks++; if (gnt_o !== 4'b0010) begin errors++; $display("[TB] FAIL lock_release_cycle: got %b expected 0010", gnt_o); end
        tick();
        @(negedge CLK_I);
        checks++; if (gnt_o !== 4'b0000) begin errors++; $display("[TB] FAIL lock_turnaround: got %b expected 0000", gnt_o); end
        tick();
        @(negedge CLK_I);
        checks++; if (gnt_o !== 4'b0001) begin errors++; $display("[TB] FAIL lock_next_owner: got %b expected 0001", gnt_o); end
        tick();
        drop_master(0);
        tick();
        tick();
    endtask

    task automatic test_timeout();
        for (int v = 0; v < 2; v++) begin
            tick();
            set_master(3, 1'b0, 32'h400);
            for (int k = 1; k <= 10; k++) begin
                tick();
                sbus.ack = (v == 1 && k == 9) ? 1'b1 : 1'b0;
                @(negedge CLK_I);
                if (k == 9) begin
                    checks++; if (timeout_o !== (v == 0)) begin errors++; $display("[TB] FAIL wd_v%0d_expiry: got timeout=%b expected %b", v, timeout_o, (v == 0)); end
                    checks++; if (mbus.err !== ((v == 0) ? 4'b1000 : 4'b0000) || mbus.ack !== ((v == 1) ? 4'b1000 : 4'b0000)) begin errors++; $display("[TB] FAIL wd_v%0d_term: got err=%b ack=%b", v, mbus.err, mbus.ack); end
                end else begin
                    checks++; if (timeout_o !== 1'b0 || mbus.err !== 4'b0000) begin errors++; $display("[TB] FAIL wd_v%0d_cycle%0d: got timeout=%b err=%b expected 0/0000", v, k, timeout_o, mbus.err); end
                end
            end
            tick();
            sbus.ack = 1'b0;
            drop_master(3);
            tick();
            tick();
        end
    endtask

    task automatic test_reset_mid_burst();
        set_master(1, 1'b0, 32'h500);
        tick();
        tick();
        sbus.ack = 1'b1;
        tick();
        sbus.ack = 1'b0;
        drop_master(1);
        tick();
        set_master(3, 1'b1, 32'h600);
        tick();
        @(negedge CLK_I);
        checks++; if (gnt_o !== 4'b1000 || sbus.cyc !== 1'b1) begin errors++; $display("[TB] FAIL rst_burst_gnt: got gnt=%b cyc=%b expected 1000/1", gnt_o, sbus.cyc); end
        tick();
        RST_I = 1'b1;
        set_master(0, 1'b0, 32'h700);
        sbus.ack = 1'b1;
        tick();
        RST_I = 1'b0;
        @(negedge CLK_I);
        checks++; if (sbus.cyc !== 1'b0 || gnt_o !== 4'b0000) begin errors++; $display("[TB] FAIL rst_mid_state: got cyc=%b gnt=%b expected 0/0000", sbus.cyc, gnt_o); end
        checks++; if (mbus.ack !== 4'b0000) begin errors++; $display("[TB] FAIL rst_mid_noack: got %b expected 0000", mbus.ack); end
        tick();
        sbus.ack = 1'b0;
        @(negedge CLK_I);
        checks++; if (gnt_o !== 4'b0001) begin errors++; $display("[TB] FAIL rst_ptr_restart: got %b expected 0001", gnt_o); end
        tick();
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_single_write();
        test_read_tags();
        test_round_robin();
        test_lock();
        test_timeout();
        test_reset_mid_burst();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL sim_time_limit: got no completion expected finish before 200000");
        $fatal(1, "[TB] time limit reached");
    end
endmodule
